// File: rtl/wave_pkg.sv
// Shared FSM state type and default parameters for the waveform measurement block.
package wave_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AMP,
      ST_XWAIT,
      ST_PERIOD,
      ST_DONE
   } state_t;

   localparam int DEF_DATA_W   = 8;
   localparam int DEF_WIN_LEN  = 256;
   localparam int DEF_PERIOD_W = 16;
   localparam int DEF_HYST     = 4;

endpackage

// File: rtl/wave_xdet.sv
// Hysteretic rising mid-level crossing detector: arms at or below lo, fires at or above mid.
module wave_xdet
   import wave_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] i_sample,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_mid,
   input  logic [DATA_W-1:0] i_lo,
   input  logic              i_clear,
   output logic              o_rise
);

   logic r_armed;

   assign o_rise = i_valid && !i_clear && r_armed && (i_sample >= i_mid);

   // A crossing disarms, so noise hovering around mid cannot fire twice.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_armed <= 1'b0;
      end else if (i_clear) begin
         r_armed <= 1'b0;
      end else if (i_valid) begin
         if (o_rise) begin
            r_armed <= 1'b0;
         end else if (i_sample <= i_lo) begin
            r_armed <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/wave_measure.sv
// Measures window min/max/peak-to-peak of an ADC sample stream, then the period
// between two hysteretic rising mid-level crossings.
module wave_measure
   import wave_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int WIN_LEN  = DEF_WIN_LEN,
   parameter int PERIOD_W = DEF_PERIOD_W,
   parameter int HYST     = DEF_HYST
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [DATA_W-1:0]   din,
   input  logic                din_valid,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic [DATA_W-1:0]   vmax,
   output logic [DATA_W-1:0]   vmin,
   output logic [DATA_W-1:0]   vpp,
   output logic [PERIOD_W-1:0] period,
   output logic                period_ok,
   output state_t              o_dbg_state
);

   localparam int                WCNT_W   = $clog2(WIN_LEN);
   localparam logic [WCNT_W-1:0] WIN_LAST = WCNT_W'(WIN_LEN - 1);
   localparam logic [DATA_W-1:0] HYST_V   = DATA_W'(HYST);
   localparam logic [DATA_W:0]   FLAT_TH  = (DATA_W+1)'(2 * HYST);

   state_t               r_state, w_state_nx;
   logic [DATA_W-1:0]    r_wmax, r_wmin, r_mid, r_lo;
   logic [WCNT_W-1:0]    r_wcnt;
   logic [PERIOD_W-1:0]  r_cnt;
   logic [DATA_W-1:0]    r_vmax, r_vmin, r_vpp;
   logic [PERIOD_W-1:0]  r_period;
   logic                 r_period_ok;

   logic                 w_first, w_win_last, w_flat, w_rise, w_det_valid, w_det_clear;
   logic [DATA_W-1:0]    w_max_nx, w_min_nx, w_vpp_nx, w_mid, w_lo;
   logic [DATA_W:0]      w_sum;
   logic [PERIOD_W-1:0]  w_cnt_inc;
   logic                 w_cnt_top;
   logic                 w_ld_res, w_res_ok;
   logic [PERIOD_W-1:0]  w_res_period;
   logic [DATA_W-1:0]    w_res_max, w_res_min;

   // Window statistics including the sample presented this cycle.
   assign w_first    = (r_wcnt == '0);
   assign w_win_last = (r_wcnt == WIN_LAST);
   assign w_max_nx   = (w_first || din > r_wmax) ? din : r_wmax;
   assign w_min_nx   = (w_first || din < r_wmin) ? din : r_wmin;
   assign w_vpp_nx   = w_max_nx - w_min_nx;
   assign w_sum      = {1'b0, w_max_nx} + {1'b0, w_min_nx};
   assign w_mid      = DATA_W'(w_sum >> 1);
   assign w_lo       = (w_mid >= HYST_V) ? (w_mid - HYST_V) : '0;
   assign w_flat     = ({1'b0, w_vpp_nx} < FLAT_TH);

   assign w_cnt_inc  = r_cnt + 1'b1;
   assign w_cnt_top  = (w_cnt_inc == '1);

   assign w_det_valid = din_valid && (r_state == ST_XWAIT || r_state == ST_PERIOD);
   assign w_det_clear = !(r_state == ST_XWAIT || r_state == ST_PERIOD);

   wave_xdet #(.DATA_W(DATA_W)) u_xdet (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_sample (din),
      .i_valid  (w_det_valid),
      .i_mid    (r_mid),
      .i_lo     (r_lo),
      .i_clear  (w_det_clear),
      .o_rise   (w_rise)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx   = r_state;
      w_ld_res     = 1'b0;
      w_res_period = '0;
      w_res_ok     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_state_nx = ST_AMP;
         end
         ST_AMP: begin
            if (din_valid && w_win_last) begin
               if (w_flat) begin
                  w_state_nx = ST_DONE;
                  w_ld_res   = 1'b1;
               end else begin
                  w_state_nx = ST_XWAIT;
               end
            end
         end
         ST_XWAIT: begin
            if (w_rise) begin
               w_state_nx = ST_PERIOD;
            end else if (din_valid && w_cnt_top) begin
               w_state_nx = ST_DONE;
               w_ld_res   = 1'b1;
            end
         end
         ST_PERIOD: begin
            if (w_rise) begin
               w_state_nx   = ST_DONE;
               w_ld_res     = 1'b1;
               w_res_period = w_cnt_inc;
               w_res_ok     = 1'b1;
            end else if (din_valid && w_cnt_top) begin
               w_state_nx = ST_DONE;
               w_ld_res   = 1'b1;
            end
         end
         ST_DONE: begin
            w_state_nx = ST_IDLE;
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   // In the flat case the result is taken in the same cycle as the last window sample.
   assign w_res_max = (r_state == ST_AMP) ? w_max_nx : r_wmax;
   assign w_res_min = (r_state == ST_AMP) ? w_min_nx : r_wmin;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wmax      <= '0;
         r_wmin      <= '0;
         r_mid       <= '0;
         r_lo        <= '0;
         r_wcnt      <= '0;
         r_cnt       <= '0;
         r_vmax      <= '0;
         r_vmin      <= '0;
         r_vpp       <= '0;
         r_period    <= '0;
         r_period_ok <= 1'b0;
      end else begin
         if (r_state == ST_AMP && din_valid) begin
            r_wmax <= w_max_nx;
            r_wmin <= w_min_nx;
            r_wcnt <= w_win_last ? '0 : r_wcnt + 1'b1;
            r_cnt  <= '0;
            if (w_win_last) begin
               r_mid <= w_mid;
               r_lo  <= w_lo;
            end
         end
         if (w_det_valid) begin
            r_cnt <= (r_state == ST_XWAIT && w_rise) ? '0 : w_cnt_inc;
         end
         if (w_ld_res) begin
            r_vmax      <= w_res_max;
            r_vmin      <= w_res_min;
            r_vpp       <= w_res_max - w_res_min;
            r_period    <= w_res_period;
            r_period_ok <= w_res_ok;
         end
      end
   end

   assign busy        = (r_state == ST_AMP) || (r_state == ST_XWAIT) || (r_state == ST_PERIOD);
   assign done        = (r_state == ST_DONE);
   assign vmax        = r_vmax;
   assign vmin        = r_vmin;
   assign vpp         = r_vpp;
   assign period      = r_period;
   assign period_ok   = r_period_ok;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wave_measure.sv
// Directed bench for wave_measure: a table of waveforms with hand-computed results,
// plus hand-written sequences for flat-signal timing and mid-measurement reset.
module tb_wave_measure;
   import wave_pkg::*;

   localparam int K_SAW    = 0;
   localparam int K_SQUARE = 1;
   localparam int K_CONST  = 2;
   localparam int K_SINE   = 3;
   localparam int K_SAW300 = 4;
   localparam int RW       = 8 * 3 + 16 + 1;

   typedef struct packed {
      logic [7:0]  vmax;
      logic [7:0]  vmin;
      logic [7:0]  vpp;
      logic [15:0] period;
      logic        ok;
   } res_t;

   typedef struct {
      int          kind;
      int          half_rate;
      int          restart_at;
      logic [7:0]  vmax;
      logic [7:0]  vmin;
      logic [7:0]  vpp;
      logic [15:0] period;
      logic        ok;
   } vec_t;

   // ---------------- clock / reset / DUTs ----------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  din = '0;
   logic        din_valid = 1'b0;
   logic        start = 1'b0;

   logic        busy, done, period_ok;
   logic [7:0]  vmax, vmin, vpp;
   logic [15:0] period;
   state_t      dbg_state;

   logic        busy8, done8, period_ok8;
   logic [7:0]  vmax8, vmin8, vpp8;
   logic [7:0]  period8;
   state_t      dbg_state8;

   always #5 clk = ~clk;

   wave_measure #(.DATA_W(8), .WIN_LEN(256), .PERIOD_W(16), .HYST(4)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .start(start),
      .busy(busy), .done(done), .vmax(vmax), .vmin(vmin), .vpp(vpp),
      .period(period), .period_ok(period_ok), .o_dbg_state(dbg_state)
   );

   wave_measure #(.DATA_W(8), .WIN_LEN(256), .PERIOD_W(8), .HYST(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .start(start),
      .busy(busy8), .done(done8), .vmax(vmax8), .vmin(vmin8), .vpp(vpp8),
      .period(period8), .period_ok(period_ok8), .o_dbg_state(dbg_state8)
   );

   // ---------------- scoreboard ----------------
   int          checks = 0;
   int          failures = 0;
   logic [RW-1:0] exp_q[$];
   int          done_cnt = 0;
   int          done8_cnt = 0;
   logic [7:0]  cap8_vmax, cap8_vpp, cap8_period;
   logic        cap8_ok;
   res_t        mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            mon_e = res_t'(exp_q.pop_front());
            chk("vmax", vmax, mon_e.vmax);
            chk("vmin", vmin, mon_e.vmin);
            chk("vpp", vpp, mon_e.vpp);
            chk("period", period, mon_e.period);
            chk("period_ok", period_ok, mon_e.ok);
         end
      end
      if (done8) begin
         done8_cnt++;
         cap8_vmax   = vmax8;
         cap8_vpp    = vpp8;
         cap8_period = period8;
         cap8_ok     = period_ok8;
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [7:0] wave_sample(input int kind, input int idx);
      int  k;
      int  b;
      real s;
      case (kind)
         K_SAW:    return 8'(idx % 256);
         K_SQUARE: return ((idx % 20) < 10) ? 8'd0 : 8'd200;
         K_CONST:  return 8'd128;
         K_SINE: begin
            k = idx % 64;
            s = 128.0 + 64.0 * $sin(6.283185307179586 * k / 64.0) + 0.5;
            b = $rtoi(s);
            if (b >= 118 && b <= 138) b = b + (((idx % 2) == 1) ? 3 : -3);
            return 8'(b);
         end
         default:  return ((idx % 300) > 255) ? 8'd255 : 8'(idx % 300);
      endcase
   endfunction

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || busy8) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("idle_before_start", busy || busy8, 0);
   endtask

   task automatic run_vec(input vec_t v);
      int   idx;
      int   cyc;
      int   d0;
      int   d8;
      res_t e;
      idx = 0;
      cyc = 0;
      wait_idle();
      e.vmax = v.vmax; e.vmin = v.vmin; e.vpp = v.vpp; e.period = v.period; e.ok = v.ok;
      exp_q.push_back(RW'(e));
      d0 = done_cnt;
      d8 = done8_cnt;
      @(negedge clk);
      start = 1'b1;
      din_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      while (!done && cyc < 5000) begin
         din       = wave_sample(v.kind, idx);
         din_valid = (v.half_rate == 0) || ((cyc % 2) == 0);
         start     = din_valid && (idx == v.restart_at);
         if (din_valid) idx++;
         cyc++;
         @(negedge clk);
      end
      din_valid = 1'b0;
      start     = 1'b0;
      if (!done) begin
         chk("done_within_budget", 0, 1);
         exp_q.delete();
      end else begin
         chk("busy_low_in_done", busy, 0);
      end
      repeat (20) @(negedge clk);
      #1;
      chk("single_done", done_cnt - d0, 1);
      chk("vmax_held", vmax, v.vmax);
      chk("period_held", period, v.period);
      if (v.kind == K_SAW300) begin
         chk("w8_single_done", done8_cnt - d8, 1);
         chk("w8_timeout_period", cap8_period, 0);
         chk("w8_timeout_ok", cap8_ok, 0);
         chk("w8_timeout_vpp", cap8_vpp, 255);
         chk("w8_timeout_vmax", cap8_vmax, 255);
      end
   endtask

   // ---------------- test ----------------
   vec_t vecs[7];

   initial begin
      int   idx;
      int   cyc;
      int   d0;
      res_t e;

      vecs[0] = '{K_SAW,    0,  -1, 8'd255, 8'd0,   8'd255, 16'd256, 1'b1};
      vecs[1] = '{K_SQUARE, 0,  -1, 8'd200, 8'd0,   8'd200, 16'd20,  1'b1};
      vecs[2] = '{K_SQUARE, 1,  -1, 8'd200, 8'd0,   8'd200, 16'd20,  1'b1};
      vecs[3] = '{K_CONST,  0,  -1, 8'd128, 8'd128, 8'd0,   16'd0,   1'b0};
      vecs[4] = '{K_SINE,   0,  -1, 8'd192, 8'd64,  8'd128, 16'd64,  1'b1};
      vecs[5] = '{K_SAW300, 0,  -1, 8'd255, 8'd0,   8'd255, 16'd300, 1'b1};
      vecs[6] = '{K_SAW,    0, 100, 8'd255, 8'd0,   8'd255, 16'd256, 1'b1};

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_vmax", vmax, 0);
      chk("rst_vmin", vmin, 0);
      chk("rst_vpp", vpp, 0);
      chk("rst_period", period, 0);
      chk("rst_period_ok", period_ok, 0);
      chk("rst_state", dbg_state, ST_IDLE);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Flat signal: done exactly one cycle after the 256th sample; start in DONE ignored
      wait_idle();
      e.vmax = 8'd128; e.vmin = 8'd128; e.vpp = 8'd0; e.period = 16'd0; e.ok = 1'b0;
      exp_q.push_back(RW'(e));
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 256; i++) begin
         din = 8'd128;
         din_valid = 1'b1;
         if (i == 255) chk("flat_no_early_done", done, 0);
         @(negedge clk);
      end
      din_valid = 1'b0;
      chk("flat_done_timing", done, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("flat_done_one_cycle", done, 0);
      chk("start_in_done_ignored", busy, 0);
      chk("start_in_done_state", dbg_state, ST_IDLE);
      repeat (3) @(negedge clk);

      // Reset while in PERIOD: outputs clear, no done afterwards
      wait_idle();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      idx = 0;
      cyc = 0;
      while (dbg_state != ST_PERIOD && cyc < 2000) begin
         din = wave_sample(K_SAW, idx);
         din_valid = 1'b1;
         idx++;
         cyc++;
         @(negedge clk);
      end
      chk("reached_period", dbg_state, ST_PERIOD);
      repeat (10) begin
         din = wave_sample(K_SAW, idx);
         idx++;
         @(negedge clk);
      end
      #1;
      d0 = done_cnt;
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_vmax", vmax, 0);
      chk("midrst_vmin", vmin, 0);
      chk("midrst_vpp", vpp, 0);
      chk("midrst_period", period, 0);
      chk("midrst_period_ok", period_ok, 0);
      chk("midrst_state", dbg_state, ST_IDLE);
      rst_n = 1'b1;
      repeat (400) begin
         din = wave_sample(K_SAW, idx);
         din_valid = 1'b1;
         idx++;
         @(negedge clk);
      end
      din_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("midrst_no_done", done_cnt - d0, 0);
      chk("midrst_stays_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
